cordic_step_sequencer: RTL and testbench
========================================

Name: cordic_step_sequencer

Overview:
- Iteration sequencer for the CORDIC datapath: counts a run-time programmable number of micro-rotation steps and supplies the datapath with step index, step enable and first/last flags.
- Supports stall, abort and continuous auto-restart, with a start/busy/done handshake toward the coprocessor control FSM.
- Sits between the command decoder, which issues start and the step count, and the CORDIC stage registers plus the arctan LUT, which are indexed by step_idx.

Parameters:
- STEP_W, 5, width of step_idx and steps_cfg; a run can be at most 2**STEP_W-1 steps.
- DEFAULT_STEPS, 25, step count used when steps_cfg==0; must be in 1..2**STEP_W-1.
- PASS_W, 8, width of the completed-pass counter (wraps).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- steps_cfg  in  STEP_W  number of steps N; 0 selects DEFAULT_STEPS; latched on accepted start.
- continuous  in  1  when high at a final step, restart immediately instead of finishing; sampled live.
- hold  in  1  stall: step_idx frozen, step_en low.
- abort  in  1  terminate the run at once, no done.
- busy  out  1  run in progress (state RUN).
- step_en  out  1  = busy & ~hold (combinational); the datapath advances on clk when high.
- step_idx  out  STEP_W  current step index, 0..N-1.
- first_step  out  1  = busy & (step_idx==0).
- last_step  out  1  = busy & (step_idx==N-1).
- done  out  1  one-cycle pulse, registered, the cycle after a final step.
- wrap  out  1  one-cycle pulse, registered, the cycle after a final step that restarted (continuous).
- aborted  out  1  one-cycle pulse, registered, the cycle after an accepted abort.
- pass_cnt  out  PASS_W  count of completed passes (done plus wrap events); wraps modulo 2**PASS_W; cleared only by rst.

Behaviour:
- Reset: async assert immediately forces state=IDLE, step_idx=0, the latched N=DEFAULT_STEPS, done=wrap=aborted=0, pass_cnt=0. Derived outputs busy, step_en, first_step and last_step are therefore 0. Applies mid-run too.
- States: IDLE, RUN.
- IDLE:
  - start=1 latches N = (steps_cfg==0) ? DEFAULT_STEPS : steps_cfg, sets step_idx=0 and moves to RUN.
  - abort in IDLE is ignored.
- RUN priority (highest first): abort > hold > advance.
  - abort=1: go to IDLE, step_idx<=0, aborted<=1 next cycle, pass_cnt unchanged. This holds regardless of hold.
  - hold=1 (no abort): all state frozen; step_en=0.
  - Advance, step_idx<N-1: step_idx<=step_idx+1.
  - Advance, step_idx==N-1, continuous=1: step_idx<=0, stay in RUN, wrap<=1, pass_cnt++.
  - Advance, step_idx==N-1, continuous=0: go to IDLE, step_idx<=0, done<=1, pass_cnt++.
  - start while in RUN is ignored. steps_cfg changes during RUN are ignored until the next accepted start, including across continuous wraps.
- Latency, no hold: start at edge T gives busy=1 and step_idx=0 after T. There are exactly N cycles with step_en=1. done=1 and busy=0 in cycle T+N+1.
- done cycle is IDLE: start asserted there is accepted, so back-to-back runs have a 1-cycle gap.
- N=1: first_step and last_step are both high in the single RUN cycle.
- The done, wrap and aborted pulses are mutually exclusive and never longer than 1 cycle unless re-triggered.
- No arithmetic overflow: step_idx never exceeds N-1 ≤ 2**STEP_W-1.

Decomposition:
- Package cordic_seq_pkg holds:
  - typedef enum logic {IDLE, RUN} seq_state_t;
  - localparam for the default DEFAULT_STEPS and STEP_W, shared with the arctan LUT depth.
- Sub-module mod_counter: generic modulo-N up-counter with clear, enable and a terminal-count output, parametrised by width. It is instantiated for step_idx, with its terminal count driving last_step. The pass counter is a plain register.

Test Plan:
- Reset values: assert rst mid-run at step_idx=7 → busy, step_idx, done, wrap, aborted and pass_cnt are 0 in the same cycle with no clock edge needed; after release, state is IDLE.
- Basic run: steps_cfg=25, 1-cycle start → 25 cycles step_en=1 with step_idx 0..24; first_step with idx 0; last_step with idx 24; done pulse 1 cycle later; pass_cnt=1.
- Default and N=1: steps_cfg=0 gives 25 steps; steps_cfg=1 gives one RUN cycle with first_step=last_step=1, then done.
- Hold/abort: N=10, hold for 3 cycles at idx 4 → idx stays 4 and step_en=0, and done arrives 3 cycles later. Abort at idx 6 together with hold=1 → IDLE next cycle, aborted=1, no done, pass_cnt unchanged.
- Continuous: N=4, continuous=1 → idx sequence 0,1,2,3,0,1… with a wrap pulse after each idx 3. Drop continuous during the 3rd pass → done after that pass ends; pass_cnt=3.
- Back-to-back/ignore: start held high through a run of N=5 → a new run begins the cycle after done (idx 0 two cycles after last_step). steps_cfg changed mid-run has no effect. pass_cnt wraps 255→0 with PASS_W=8.

Source files
------------

// File: rtl/cordic_step_sequencer_pkg.sv
// Shared types and defaults for the CORDIC step sequencer and the arctan LUT.
package cordic_seq_pkg;

  typedef enum logic {IDLE, RUN} seq_state_t;

  // Step index width; also sets the depth of the arctan LUT.
  localparam int CORDIC_STEP_W        = 5;
  // Run length used when the command carries a step count of zero.
  localparam int CORDIC_DEFAULT_STEPS = 25;
  // Width of the completed-pass counter.
  localparam int CORDIC_PASS_W        = 8;

endpackage

// File: rtl/cordic_step_sequencer_if.sv
// Handshake and step-control bundle between the command side and the sequencer.
interface cordic_step_sequencer_if
  import cordic_seq_pkg::*;
#(
  parameter int STEP_W = CORDIC_STEP_W,
  parameter int PASS_W = CORDIC_PASS_W
);

  logic              start;
  logic [STEP_W-1:0] steps_cfg;
  logic              continuous;
  logic              hold;
  logic              abort;
  logic              busy;
  logic              step_en;
  logic [STEP_W-1:0] step_idx;
  logic              first_step;
  logic              last_step;
  logic              done;
  logic              wrap;
  logic              aborted;
  logic [PASS_W-1:0] pass_cnt;

  // Command decoder / control FSM side.
  modport master (
    output start, steps_cfg, continuous, hold, abort,
    input  busy, step_en, step_idx, first_step, last_step,
    input  done, wrap, aborted, pass_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, steps_cfg, continuous, hold, abort,
    output busy, step_en, step_idx, first_step, last_step,
    output done, wrap, aborted, pass_cnt
  );

endinterface

// File: rtl/cordic_step_sequencer_mod_counter.sv
// Generic modulo up-counter: counts 0..last_val and returns to 0 after last_val.
module mod_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last_val);

  // Next count: clear wins, otherwise wrap to zero at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cordic_step_sequencer.sv
// CORDIC iteration sequencer: steps the datapath through N micro-rotations,
// with hold, abort and continuous restart, and counts completed passes.
module cordic_step_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int STEP_W        = CORDIC_STEP_W,
  parameter int DEFAULT_STEPS = CORDIC_DEFAULT_STEPS,
  parameter int PASS_W        = CORDIC_PASS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_step_sequencer_if.slave  sq
);

  // Terminal step index for a requested count; zero selects the default length.
  function automatic logic [STEP_W-1:0] last_idx_of(input logic [STEP_W-1:0] cfg);
    if (cfg == '0) begin
      return STEP_W'(DEFAULT_STEPS - 1);
    end
    return cfg - STEP_W'(1);
  endfunction

  seq_state_t        state_q, state_d;
  logic [STEP_W-1:0] last_idx_q, last_idx_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;
  logic              aborted_q, aborted_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;

  logic              busy;
  logic              accept;
  logic              kill;
  logic              advance;
  logic              final_adv;
  logic              ctr_clr;
  logic [STEP_W-1:0] step_idx;
  logic              step_tc;

  assign busy      = (state_q == RUN);
  assign accept    = (state_q == IDLE) && sq.start;
  assign kill      = busy && sq.abort;
  assign advance   = busy && !sq.abort && !sq.hold;
  assign final_adv = advance && step_tc;
  // Starting a run or aborting one both force the index back to zero.
  assign ctr_clr   = accept || kill;

  mod_counter #(
    .W (STEP_W)
  ) u_step_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .en       (advance),
    .last_val (last_idx_q),
    .cnt      (step_idx),
    .tc       (step_tc)
  );

  // Next-state, latched run length, event pulses and pass count.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    aborted_d  = 1'b0;
    pass_cnt_d = pass_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sq.start) begin
          last_idx_d = last_idx_of(sq.steps_cfg);
          state_d    = RUN;
        end
      end
      RUN: begin
        if (sq.abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (final_adv) begin
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          if (sq.continuous) begin
            wrap_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and event registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_idx_q <= STEP_W'(DEFAULT_STEPS - 1);
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      aborted_q  <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      aborted_q  <= aborted_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign sq.busy       = busy;
  assign sq.step_en    = busy && !sq.hold;
  assign sq.step_idx   = step_idx;
  assign sq.first_step = busy && (step_idx == '0);
  assign sq.last_step  = busy && step_tc;
  assign sq.done       = done_q;
  assign sq.wrap       = wrap_q;
  assign sq.aborted    = aborted_q;
  assign sq.pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_cordic_step_sequencer.sv
// Directed bench for the CORDIC step sequencer.
module tb_cordic_step_sequencer;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  int   n_run;

  cordic_step_sequencer_if #(.STEP_W(5), .PASS_W(8)) b ();

  cordic_step_sequencer #(
    .STEP_W        (5),
    .DEFAULT_STEPS (25),
    .PASS_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sq  (b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n);
    b.steps_cfg = 5'(n);
    b.start     = 1'b1;
    tick();
    b.start     = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    b.start = 1'b0;
    b.steps_cfg = '0;
    b.continuous = 1'b0;
    b.hold = 1'b0;
    b.abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_val("init_busy", 32'(b.busy), 0);
    chk_val("init_idx", 32'(b.step_idx), 0);
    chk_val("init_pass", 32'(b.pass_cnt), 0);
    chk_val("init_done", 32'(b.done), 0);

    // Basic run of 25 steps.
    start_run(25);
    for (int i = 0; i < 25; i++) begin
      chk_val("basic_idx", 32'(b.step_idx), 32'(i));
      chk_val("basic_en", 32'(b.step_en), 1);
      chk_val("basic_first", 32'(b.first_step), 32'(i == 0));
      chk_val("basic_last", 32'(b.last_step), 32'(i == 24));
      tick();
    end
    chk_val("basic_done", 32'(b.done), 1);
    chk_val("basic_busy", 32'(b.busy), 0);
    chk_val("basic_pass", 32'(b.pass_cnt), 1);
    tick();
    chk_val("basic_done_clr", 32'(b.done), 0);

    // steps_cfg = 0 selects the default of 25.
    start_run(0);
    n_run = 0;
    while (b.busy && n_run < 40) begin
      n_run++;
      tick();
    end
    chk_val("dflt_len", 32'(n_run), 25);
    chk_val("dflt_done", 32'(b.done), 1);
    chk_val("dflt_pass", 32'(b.pass_cnt), 2);

    // Single-step run.
    start_run(1);
    chk_val("n1_first", 32'(b.first_step), 1);
    chk_val("n1_last", 32'(b.last_step), 1);
    chk_val("n1_en", 32'(b.step_en), 1);
    tick();
    chk_val("n1_done", 32'(b.done), 1);
    chk_val("n1_busy", 32'(b.busy), 0);
    chk_val("n1_pass", 32'(b.pass_cnt), 3);

    // Hold for three cycles at index 4 of a 10-step run.
    start_run(10);
    repeat (4) tick();
    chk_val("hold_pre_idx", 32'(b.step_idx), 4);
    b.hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_val("hold_en", 32'(b.step_en), 0);
      chk_val("hold_idx", 32'(b.step_idx), 4);
      chk_val("hold_busy", 32'(b.busy), 1);
      tick();
    end
    b.hold = 1'b0;
    #1;
    chk_val("hold_rel_idx", 32'(b.step_idx), 4);
    chk_val("hold_rel_en", 32'(b.step_en), 1);
    repeat (5) tick();
    chk_val("hold_last_idx", 32'(b.step_idx), 9);
    chk_val("hold_no_done", 32'(b.done), 0);
    chk_val("hold_last", 32'(b.last_step), 1);
    tick();
    chk_val("hold_done", 32'(b.done), 1);
    chk_val("hold_pass", 32'(b.pass_cnt), 4);

    // Abort at index 6 while hold is also asserted.
    start_run(10);
    repeat (6) tick();
    chk_val("abt_pre_idx", 32'(b.step_idx), 6);
    b.hold = 1'b1;
    b.abort = 1'b1;
    #1;
    chk_val("abt_en", 32'(b.step_en), 0);
    tick();
    b.hold = 1'b0;
    b.abort = 1'b0;
    #1;
    chk_val("abt_busy", 32'(b.busy), 0);
    chk_val("abt_pulse", 32'(b.aborted), 1);
    chk_val("abt_no_done", 32'(b.done), 0);
    chk_val("abt_pass", 32'(b.pass_cnt), 4);
    chk_val("abt_idx", 32'(b.step_idx), 0);
    tick();
    chk_val("abt_pulse_clr", 32'(b.aborted), 0);
    b.abort = 1'b1;
    tick();
    chk_val("abt_idle_ign", 32'(b.aborted), 0);
    chk_val("abt_idle_busy", 32'(b.busy), 0);
    b.abort = 1'b0;

    // Asynchronous reset in the middle of a run, between clock edges.
    start_run(25);
    repeat (7) tick();
    chk_val("rst_pre_idx", 32'(b.step_idx), 7);
    #2;
    rst = 1'b1;
    #1;
    chk_val("rst_busy", 32'(b.busy), 0);
    chk_val("rst_idx", 32'(b.step_idx), 0);
    chk_val("rst_en", 32'(b.step_en), 0);
    chk_val("rst_done", 32'(b.done), 0);
    chk_val("rst_wrap", 32'(b.wrap), 0);
    chk_val("rst_aborted", 32'(b.aborted), 0);
    chk_val("rst_pass", 32'(b.pass_cnt), 0);
    tick();
    rst = 1'b0;
    tick();
    chk_val("rst_rel_busy", 32'(b.busy), 0);

    // Continuous 4-step runs; continuous dropped during the third pass.
    b.continuous = 1'b1;
    start_run(4);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (p == 2 && i == 1) begin
          b.continuous = 1'b0;
          #1;
        end
        chk_val("cont_idx", 32'(b.step_idx), 32'(i));
        chk_val("cont_wrap", 32'(b.wrap), 32'(i == 0 && p > 0));
        chk_val("cont_last", 32'(b.last_step), 32'(i == 3));
        tick();
      end
    end
    chk_val("cont_done", 32'(b.done), 1);
    chk_val("cont_wrap_end", 32'(b.wrap), 0);
    chk_val("cont_busy", 32'(b.busy), 0);
    chk_val("cont_pass", 32'(b.pass_cnt), 3);

    // start held through a 5-step run; steps_cfg changed mid-run.
    b.steps_cfg = 5'd5;
    b.start = 1'b1;
    tick();
    b.steps_cfg = 5'd2;
    for (int i = 0; i < 5; i++) begin
      chk_val("b2b_idx", 32'(b.step_idx), 32'(i));
      chk_val("b2b_busy", 32'(b.busy), 1);
      tick();
    end
    chk_val("b2b_done", 32'(b.done), 1);
    chk_val("b2b_gap", 32'(b.busy), 0);
    tick();
    chk_val("b2b_restart", 32'(b.busy), 1);
    chk_val("b2b_idx0", 32'(b.step_idx), 0);
    chk_val("b2b_first", 32'(b.first_step), 1);
    b.start = 1'b0;
    tick();
    chk_val("b2b_n2_idx", 32'(b.step_idx), 1);
    chk_val("b2b_n2_last", 32'(b.last_step), 1);
    tick();
    chk_val("b2b_n2_done", 32'(b.done), 1);
    chk_val("b2b_pass", 32'(b.pass_cnt), 5);

    // Pass counter wraps 255 -> 0 using continuous single-step runs.
    b.continuous = 1'b1;
    start_run(1);
    chk_val("pw_start_pass", 32'(b.pass_cnt), 5);
    repeat (250) tick();
    chk_val("pw_255", 32'(b.pass_cnt), 255);
    chk_val("pw_wrap_a", 32'(b.wrap), 1);
    tick();
    chk_val("pw_0", 32'(b.pass_cnt), 0);
    chk_val("pw_wrap_b", 32'(b.wrap), 1);
    b.continuous = 1'b0;
    tick();
    chk_val("pw_done", 32'(b.done), 1);
    chk_val("pw_wrap_end", 32'(b.wrap), 0);
    chk_val("pw_pass", 32'(b.pass_cnt), 1);
    chk_val("pw_busy", 32'(b.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
